rst_sync_seq: RTL and testbench
===============================

Name: rst_sync_seq

Overview:
- Parametrised successor to the two-flop reset synchroniser.
- Synchronises the asynchronous active-low system reset into the CLK domain.
- Holds all downstream resets for a minimum stretch period, then releases NUM_CH active-low reset channels one at a time, in index order, with a programmable gap between releases.
- Accepts a synchronous software reset request and reports sequence completion.
- Sits at the root of each clock domain and feeds the reset inputs of that domain's blocks (e.g. channel 0 for the register file, channel 1 for the datapath, channel 2 for the UART/FIFO).

Parameters:
- NUM_STAGES, 2: synchroniser flop count; legal range ≥ 2.
- NUM_CH, 3: number of sequenced reset outputs; legal range ≥ 1.
- STRETCH_CYCLES, 8: cycles all channels stay asserted after synchronised deassertion; legal range ≥ 1.
- GAP_CYCLES, 4: cycles between consecutive channel releases; legal range ≥ 1.

Ports:
- CLK, input, 1: domain clock.
- RST, input, 1: reset, asynchronous, active-low.
- SW_RST_REQ, input, 1: synchronous single-cycle software reset request, CLK domain.
- Sync_RST, output, NUM_CH: active-low reset per channel; bit i is released in order i.
- RST_DONE, output, 1: high when all channels are released and the sequence is idle.

Behaviour:
- Interface: reset RST, asynchronous, active-low; clock CLK.
- While RST=0, asynchronously and immediately:
  - all synchroniser flops = 0
  - Sync_RST = all 0
  - RST_DONE = 0
  - counters = 0
  - state = HOLD
- Synchroniser: NUM_STAGES-flop shift chain fed with 1'b1. Its output sync_n goes high at edge NUM_STAGES, where edge k is the k-th CLK rising edge after RST rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: HOLD, STRETCH, RELEASE, RUN.
- HOLD:
  - When sync_n=1 at an edge: go to STRETCH and load cnt = STRETCH_CYCLES-1.
  - Sync_RST stays all 0.
- STRETCH:
  - Decrement cnt each edge.
  - At the edge where cnt==0:
    - set Sync_RST[0]=1
    - ch_idx = 1
    - if NUM_CH==1: set RST_DONE=1 and go to RUN
    - otherwise: load cnt = GAP_CYCLES-1 and go to RELEASE
- RELEASE:
  - Decrement cnt each edge.
  - At the edge where cnt==0:
    - set Sync_RST[ch_idx]=1
    - if ch_idx==NUM_CH-1: set RST_DONE=1 (same edge) and go to RUN
    - otherwise: increment ch_idx and reload cnt = GAP_CYCLES-1
- RUN: all Sync_RST = 1, RST_DONE = 1; stays here until SW_RST_REQ or RST.
- Release timing: channel i releases at edge NUM_STAGES + 1 + STRETCH_CYCLES + i·GAP_CYCLES. With defaults: ch0 at edge 11, ch1 at 15, ch2 at 19; RST_DONE at 19.
- SW_RST_REQ=1 sampled in STRETCH, RELEASE or RUN; at the next edge:
  - Sync_RST = all 0, RST_DONE = 0
  - ch_idx = 1, cnt = STRETCH_CYCLES-1
  - state = STRETCH
  - The synchroniser is not affected.
  - A request during STRETCH restarts the stretch count.
- SW_RST_REQ in HOLD is ignored.
- SW_RST_REQ held high for several cycles: the block stays in STRETCH with cnt reloaded every cycle. Release starts STRETCH_CYCLES cycles after the last high sample.
- RST falling in any state (mid-stretch or mid-release): immediate asynchronous return to full reset. The next RST rise repeats the full sequence from edge 1.
- Once a channel is released it is never re-asserted except by RST or SW_RST_REQ; there are no glitches.
- Widths:
  - cnt is $clog2(max(STRETCH_CYCLES, GAP_CYCLES)+1) bits.
  - ch_idx is max(1, $clog2(NUM_CH)) bits.
  - Decrements never underflow, because the reload happens at cnt==0.
- Glitch-free reset outputs: each Sync_RST bit comes directly from a flop.

Decomposition:
- Shared package rst_pkg holds:
  - the FSM state encoding (HOLD=2'd0, STRETCH=2'd1, RELEASE=2'd2, RUN=2'd3)
  - a max() helper constant function for the counter width
- Sub-module rst_sync_chain (parameter NUM_STAGES, ports RST, CLK, sync_n) is the plain synchroniser chain. It is reusable standalone for single-channel domains.
- The sequencer FSM and counters live in the top level.

Test Plan:
1. Defaults, RST low 5 cycles then high (mid-cycle) -> Sync_RST=3'b000 through edge 10, 3'b001 at edge 11, 3'b011 at 15, 3'b111 at 19; RST_DONE rises at 19.
2. RST asserted asynchronously mid-cycle while in RUN -> Sync_RST=000 and RST_DONE=0 within the same cycle, without waiting for a CLK edge; a re-release repeats scenario 1 timing.
3. RUN, single-cycle SW_RST_REQ at edge N -> Sync_RST=000 at N+1; ch0 at N+1+8, ch1 at N+13, ch2 at N+17; RST_DONE at N+17.
4. SW_RST_REQ during RELEASE just after ch0 release (Sync_RST=001) -> 000 next edge, full stretch restart; SW_RST_REQ held 3 cycles -> release timed from the last high cycle.
5. RST re-asserted at edge 13 (Sync_RST=001) -> immediate 000; ch1 never releases early; clean restart after RST rises.
6. Parameter sweep NUM_CH=1, STRETCH_CYCLES=1, GAP_CYCLES=1, NUM_STAGES=3 -> Sync_RST[0] and RST_DONE rise together at edge 5; no X on any output.

Source files
------------

// File: rtl/rst_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding and a width helper.
package rst_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } rst_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Plain N-flop reset synchroniser: async assert, release after NUM_STAGES CLK edges.
module rst_sync_chain #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic sync_n
);

    logic [NUM_STAGES-1:0] chain_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[NUM_STAGES-2:0], 1'b1};
        end
    end

    assign sync_n = chain_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_sync_seq.sv
// Reset synchroniser plus sequencer: stretches reset, then releases channels in index order.
module rst_sync_seq
    import rst_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 2,
    parameter int unsigned NUM_CH         = 3,
    parameter int unsigned STRETCH_CYCLES = 8,
    parameter int unsigned GAP_CYCLES     = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SW_RST_REQ,
    output logic [NUM_CH-1:0] Sync_RST,
    output logic              RST_DONE
);

    localparam int unsigned CNT_W = $clog2(max_u(STRETCH_CYCLES, GAP_CYCLES) + 1);
    localparam int unsigned CH_W  = max_u(1, $clog2(NUM_CH));

    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(NUM_CH - 1);

    logic sync_n;

    rst_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              done_q, done_d;
    logic              sw_restart;

    rst_sync_chain #(
        .NUM_STAGES(NUM_STAGES)
    ) u_chain (
        .CLK    (CLK),
        .RST    (RST),
        .sync_n (sync_n)
    );

    // Software request is honoured only once the synchroniser has released.
    assign sw_restart = SW_RST_REQ && (state_q != HOLD);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            ch_idx_q <= '0;
            rst_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_idx_q <= ch_idx_d;
            rst_q    <= rst_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_idx_d = ch_idx_q;
        unique case (state_q)
            HOLD: begin
                if (sync_n) begin
                    state_d = STRETCH;
                    cnt_d   = STRETCH_LOAD;
                end
            end
            STRETCH: begin
                if (cnt_q == '0) begin
                    ch_idx_d = CH_W'(1);
                    if (NUM_CH == 1) begin
                        state_d = RUN;
                    end else begin
                        state_d = RELEASE;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                if (cnt_q == '0) begin
                    if (ch_idx_q == LAST_CH) begin
                        state_d = RUN;
                    end else begin
                        ch_idx_d = ch_idx_q + 1'b1;
                        cnt_d    = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
        if (sw_restart) begin
            state_d  = STRETCH;
            cnt_d    = STRETCH_LOAD;
            ch_idx_d = CH_W'(1);
        end
    end

    always_comb begin
        rst_d  = rst_q;
        done_d = done_q;
        if (state_q == STRETCH && cnt_q == '0) begin
            rst_d[0] = 1'b1;
            done_d   = (NUM_CH == 1);
        end else if (state_q == RELEASE && cnt_q == '0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx_q == CH_W'(i)) begin
                    rst_d[i] = 1'b1;
                end
            end
            done_d = (ch_idx_q == LAST_CH);
        end
        if (sw_restart) begin
            rst_d  = '0;
            done_d = 1'b0;
        end
    end

    assign Sync_RST = rst_q;
    assign RST_DONE = done_q;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Directed bench: default sequencer plus a single-channel minimal-timing instance.
module tb_rst_sync_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SW_RST_REQ = 1'b0;
    logic [2:0] Sync_RST;
    logic       RST_DONE;
    logic [0:0] sync1;
    logic       done1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    rst_sync_seq dut (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .Sync_RST   (Sync_RST),
        .RST_DONE   (RST_DONE)
    );

    rst_sync_seq #(
        .NUM_STAGES     (3),
        .NUM_CH         (1),
        .STRETCH_CYCLES (1),
        .GAP_CYCLES     (1)
    ) dut1 (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .Sync_RST   (sync1),
        .RST_DONE   (done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Default-instance expectations k edges into a sequence whose ch0 releases at edge first.
    task automatic chk_seq(input string tag, input int k, input int first);
        logic [2:0] exp_rst;
        for (int i = 0; i < 3; i++) exp_rst[i] = (k >= first + 4 * i);
        chk($sformatf("%s rst k%0d", tag, k), 32'(Sync_RST), 32'(exp_rst));
        chk($sformatf("%s done k%0d", tag, k), 32'(RST_DONE), 32'(k >= first + 8));
    endtask

    // Full power-on sequence from RST rising: both instances checked every edge.
    task automatic por_seq(input string tag);
        @(negedge CLK);
        RST = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            chk_seq(tag, e, 11);
            chk($sformatf("%s rst1 e%0d", tag, e), 32'(sync1), 32'(e >= 5));
            chk($sformatf("%s done1 e%0d", tag, e), 32'(done1), 32'(e >= 5));
        end
    endtask

    initial begin
        // Reset state
        for (int c = 0; c < 5; c++) step();
        chk("reset rst", 32'(Sync_RST), 32'h0);
        chk("reset done", 32'(RST_DONE), 32'h0);
        chk("reset rst1", 32'(sync1), 32'h0);
        chk("reset done1", 32'(done1), 32'h0);

        // 1 + 6: power-on sequence, both parameter sets
        por_seq("t1");

        // 2: asynchronous assertion from RUN, then repeat
        #2;
        RST = 1'b0;
        #1;
        chk("t2 async rst", 32'(Sync_RST), 32'h0);
        chk("t2 async done", 32'(RST_DONE), 32'h0);
        chk("t2 async rst1", 32'(sync1), 32'h0);
        step();
        step();
        chk("t2 held rst", 32'(Sync_RST), 32'h0);
        por_seq("t2");

        // 3: single-cycle software request from RUN
        @(negedge CLK);
        SW_RST_REQ = 1'b1;
        step();
        SW_RST_REQ = 1'b0;
        chk_seq("t3", 1, 9);
        for (int k = 2; k <= 20; k++) begin
            step();
            chk_seq("t3", k, 9);
        end

        // 4a: request just after ch0 release restarts the stretch
        @(negedge CLK);
        SW_RST_REQ = 1'b1;
        step();
        SW_RST_REQ = 1'b0;
        for (int k = 2; k <= 10; k++) step();
        chk("t4 ch0 only", 32'(Sync_RST), 32'h1);
        @(negedge CLK);
        SW_RST_REQ = 1'b1;
        step();
        SW_RST_REQ = 1'b0;
        chk_seq("t4a", 1, 9);
        for (int k = 2; k <= 12; k++) begin
            step();
            chk_seq("t4a", k, 9);
        end

        // 4b: request held for three samples; timing from the last one
        @(negedge CLK);
        SW_RST_REQ = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            step();
            if (j == 3) SW_RST_REQ = 1'b0;
            chk_seq("t4b", j, 11);
        end
        for (int j = 4; j <= 20; j++) begin
            step();
            chk_seq("t4b", j, 11);
        end

        // 5: RST re-asserted while only ch0 is released
        @(negedge CLK);
        RST = 1'b0;
        step();
        step();
        @(negedge CLK);
        RST = 1'b1;
        for (int e = 1; e <= 13; e++) step();
        chk("t5 e13 rst", 32'(Sync_RST), 32'h1);
        chk("t5 e13 done", 32'(RST_DONE), 32'h0);
        #2;
        RST = 1'b0;
        #1;
        chk("t5 async rst", 32'(Sync_RST), 32'h0);
        for (int c = 0; c < 4; c++) step();
        chk("t5 no early ch1", 32'(Sync_RST), 32'h0);
        por_seq("t5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
